// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store controller: funct3 encodings,
// response error codes, FSM state type and the store byte-mask helper.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_RANGE    = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_t;

    // Byte-enable pattern for a store of the given size (low bytes first).
    function automatic logic [3:0] store_bmask(input logic [2:0] f3);
        logic [3:0] m;
        case (f3)
            F3_B:    m = 4'b0001;
            F3_H:    m = 4'b0011;
            F3_W:    m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Combinational load-data extender: selects the loaded width from funct3
// and sign- or zero-extends it to 32 bits.
module lsu_load_ext
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_data
);

    // Width select and extension of the raw memory word.
    always_comb begin
        case (i_funct3)
            F3_B:    o_data = {{24{i_rdata[7]}}, i_rdata[7:0]};
            F3_H:    o_data = {{16{i_rdata[15]}}, i_rdata[15:0]};
            F3_BU:   o_data = {24'd0, i_rdata[7:0]};
            F3_HU:   o_data = {16'd0, i_rdata[15:0]};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: accepts one request, validates it, performs a
// single-cycle memory access and returns the (extended) result or an
// error code over a valid/ready response channel.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 11
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [2:0]        i_req_funct3,
    input  logic [31:0]       i_req_addr,
    input  logic [31:0]       i_req_wdata,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [31:0]       o_rsp_rdata,
    output logic [1:0]        o_rsp_err,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    output logic [3:0]        o_mem_bmask,
    output logic              o_mem_wren,
    input  logic [31:0]       i_mem_rdata
);

    lsu_state_t        state_q, state_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic [1:0]        rsp_err_q, rsp_err_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_bmask_q, mem_bmask_d;
    logic              mem_wren_q, mem_wren_d;
    logic [31:0]       ext_data;
    logic [1:0]        req_err;

    // Request checks; illegal funct3 wins over misalignment, which wins over range.
    function automatic logic [1:0] check_req(input logic we, input logic [2:0] f3,
                                             input logic [31:0] addr);
        logic illegal, misalign, range_bad;
        illegal   = we ? (f3 != F3_B && f3 != F3_H && f3 != F3_W)
                       : (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
        misalign  = ((f3[1:0] == 2'b01) && addr[0]) ||
                    ((f3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        range_bad = ((addr >> ADDR_W) != 32'd0);
        if (illegal)        return ERR_ILLEGAL;
        else if (misalign)  return ERR_MISALIGN;
        else if (range_bad) return ERR_RANGE;
        else                return ERR_OK;
    endfunction

    lsu_load_ext u_load_ext (
        .i_funct3 (funct3_q),
        .i_rdata  (i_mem_rdata),
        .o_data   (ext_data)
    );

    assign req_err = check_req(i_req_we, i_req_funct3, i_req_addr);

    // Next-state and next-output computation for the IDLE/ACCESS/RESP sequence.
    always_comb begin
        state_d     = state_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        funct3_d    = funct3_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_bmask_d = mem_bmask_q;
        mem_wren_d  = mem_wren_q;
        case (state_q)
            IDLE: begin
                if (i_req_valid) begin
                    funct3_d    = i_req_funct3;
                    rsp_rdata_d = 32'd0;
                    if (req_err == ERR_OK) begin
                        state_d     = ACCESS;
                        mem_addr_d  = i_req_addr[ADDR_W-1:0];
                        mem_wren_d  = i_req_we;
                        mem_wdata_d = i_req_we ? i_req_wdata : 32'd0;
                        mem_bmask_d = i_req_we ? store_bmask(i_req_funct3) : 4'b0000;
                    end else begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = req_err;
                    end
                end
            end
            ACCESS: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = ERR_OK;
                rsp_rdata_d = mem_wren_q ? 32'd0 : ext_data;
                mem_addr_d  = '0;
                mem_wdata_d = 32'd0;
                mem_bmask_d = 4'b0000;
                mem_wren_d  = 1'b0;
            end
            RESP: begin
                if (i_rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = 32'd0;
                    rsp_err_d   = ERR_OK;
                end
            end
            default: state_d = IDLE;
        endcase
        req_ready_d = (state_d == IDLE);
    end

    // State and registered outputs; reset aborts any in-flight transaction.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= ERR_OK;
            funct3_q    <= 3'b000;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
            mem_bmask_q <= 4'b0000;
            mem_wren_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            funct3_q    <= funct3_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_bmask_q <= mem_bmask_d;
            mem_wren_q  <= mem_wren_d;
        end
    end

    assign o_req_ready = req_ready_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_rdata = rsp_rdata_q;
    assign o_rsp_err   = rsp_err_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_wdata = mem_wdata_q;
    assign o_mem_bmask = mem_bmask_q;
    assign o_mem_wren  = mem_wren_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a byte-addressed memory model.
module tb_lsu_ctrl;

    localparam int ADDR_W = 11;

    logic              i_clk = 1'b0;
    logic              i_reset;
    logic              i_req_valid;
    logic              o_req_ready;
    logic              i_req_we;
    logic [2:0]        i_req_funct3;
    logic [31:0]       i_req_addr;
    logic [31:0]       i_req_wdata;
    logic              o_rsp_valid;
    logic              i_rsp_ready;
    logic [31:0]       o_rsp_rdata;
    logic [1:0]        o_rsp_err;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [31:0]       o_mem_wdata;
    logic [3:0]        o_mem_bmask;
    logic              o_mem_wren;
    logic [31:0]       i_mem_rdata;

    logic [7:0] mem [0:2047] = '{default: 8'h00};
    int n_assert = 0;
    int n_fail   = 0;

    lsu_ctrl #(.ADDR_W(ADDR_W)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_we     (i_req_we),
        .i_req_funct3 (i_req_funct3),
        .i_req_addr   (i_req_addr),
        .i_req_wdata  (i_req_wdata),
        .o_rsp_valid  (o_rsp_valid),
        .i_rsp_ready  (i_rsp_ready),
        .o_rsp_rdata  (o_rsp_rdata),
        .o_rsp_err    (o_rsp_err),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wdata  (o_mem_wdata),
        .o_mem_bmask  (o_mem_bmask),
        .o_mem_wren   (o_mem_wren),
        .i_mem_rdata  (i_mem_rdata)
    );

    always #5 i_clk = ~i_clk;

    // Asynchronous read: byte [7:0] comes from o_mem_addr.
    always_comb begin
        i_mem_rdata = {mem[o_mem_addr + 11'd3], mem[o_mem_addr + 11'd2],
                       mem[o_mem_addr + 11'd1], mem[o_mem_addr]};
    end

    // Byte-masked synchronous write.
    always @(posedge i_clk) begin
        if (o_mem_wren) begin
            for (int k = 0; k < 4; k++)
                if (o_mem_bmask[k])
                    mem[o_mem_addr + ADDR_W'(k)] <= o_mem_wdata[8*k +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input int a);
        return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
    endfunction

    // One complete transaction with rsp_ready asserted once the response appears.
    task automatic txn(input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] exp_err, input logic [31:0] exp_rdata,
                       input logic [3:0] exp_bmask);
        chk({tag, ".req_ready"}, 32'(o_req_ready), 32'd1);
        i_req_valid  = 1'b1;
        i_req_we     = we;
        i_req_funct3 = f3;
        i_req_addr   = addr;
        i_req_wdata  = wdata;
        @(posedge i_clk);
        @(negedge i_clk);
        i_req_valid = 1'b0;
        if (exp_err == 2'b00) begin
            chk({tag, ".acc_wren"},  32'(o_mem_wren),  32'(we));
            chk({tag, ".acc_bmask"}, 32'(o_mem_bmask), 32'(exp_bmask));
            chk({tag, ".acc_addr"},  32'(o_mem_addr),  {21'd0, addr[10:0]});
            if (we) chk({tag, ".acc_wdata"}, o_mem_wdata, wdata);
            chk({tag, ".acc_rsp_valid"}, 32'(o_rsp_valid), 32'd0);
            chk({tag, ".acc_req_ready"}, 32'(o_req_ready), 32'd0);
            @(posedge i_clk);
            @(negedge i_clk);
        end
        chk({tag, ".rsp_valid"}, 32'(o_rsp_valid), 32'd1);
        chk({tag, ".rsp_err"},   32'(o_rsp_err),   32'(exp_err));
        chk({tag, ".rsp_rdata"}, o_rsp_rdata,      exp_rdata);
        chk({tag, ".rsp_wren"},  32'(o_mem_wren),  32'd0);
        chk({tag, ".rsp_bmask"}, 32'(o_mem_bmask), 32'd0);
        i_rsp_ready = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_rsp_ready = 1'b0;
        chk({tag, ".done_valid"}, 32'(o_rsp_valid), 32'd0);
        chk({tag, ".done_ready"}, 32'(o_req_ready), 32'd1);
    endtask

    initial begin
        i_reset      = 1'b1;
        i_req_valid  = 1'b0;
        i_req_we     = 1'b0;
        i_req_funct3 = 3'b000;
        i_req_addr   = 32'd0;
        i_req_wdata  = 32'd0;
        i_rsp_ready  = 1'b0;
        repeat (2) @(negedge i_clk);

        chk("rst.req_ready", 32'(o_req_ready), 32'd1);
        chk("rst.rsp_valid", 32'(o_rsp_valid), 32'd0);
        chk("rst.rsp_rdata", o_rsp_rdata,      32'd0);
        chk("rst.rsp_err",   32'(o_rsp_err),   32'd0);
        chk("rst.mem_addr",  32'(o_mem_addr),  32'd0);
        chk("rst.mem_wdata", o_mem_wdata,      32'd0);
        chk("rst.mem_bmask", 32'(o_mem_bmask), 32'd0);
        chk("rst.mem_wren",  32'(o_mem_wren),  32'd0);
        i_reset = 1'b0;
        @(negedge i_clk);

        // Word store / load round trip and sub-word loads with extension.
        txn("sw_10",  1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 2'b00, 32'h0, 4'b1111);
        chk("mem_10", mem_word(32'h10), 32'hDEADBEEF);
        txn("lw_10",  1'b0, 3'b010, 32'h10, 32'h0, 2'b00, 32'hDEADBEEF, 4'b0000);
        txn("lb_13",  1'b0, 3'b000, 32'h13, 32'h0, 2'b00, 32'hFFFFFFDE, 4'b0000);
        txn("lbu_13", 1'b0, 3'b100, 32'h13, 32'h0, 2'b00, 32'h000000DE, 4'b0000);
        txn("lh_12",  1'b0, 3'b001, 32'h12, 32'h0, 2'b00, 32'hFFFFDEAD, 4'b0000);
        txn("lhu_10", 1'b0, 3'b101, 32'h10, 32'h0, 2'b00, 32'h0000BEEF, 4'b0000);

        // Sub-word stores touch only their bytes.
        txn("sb_21",  1'b1, 3'b000, 32'h21, 32'h123456AA, 2'b00, 32'h0, 4'b0001);
        chk("mem_20_sb", mem_word(32'h20), 32'h0000AA00);
        txn("sh_22",  1'b1, 3'b001, 32'h22, 32'h0000BBCC, 2'b00, 32'h0, 4'b0011);
        txn("lw_20",  1'b0, 3'b010, 32'h20, 32'h0, 2'b00, 32'hBBCCAA00, 4'b0000);
        txn("lb_21",  1'b0, 3'b000, 32'h21, 32'h0, 2'b00, 32'hFFFFFFAA, 4'b0000);

        // Error responses, no memory access.
        txn("lw_mis",   1'b0, 3'b010, 32'h11,  32'h0, 2'b01, 32'h0, 4'b0000);
        txn("lh_range", 1'b0, 3'b001, 32'h800, 32'h0, 2'b10, 32'h0, 4'b0000);
        txn("ld_ill",   1'b0, 3'b011, 32'h10,  32'h0, 2'b11, 32'h0, 4'b0000);
        txn("st_ill",   1'b1, 3'b100, 32'h801, 32'h55555555, 2'b11, 32'h0, 4'b0000);
        txn("sw_mis",   1'b1, 3'b010, 32'h12,  32'h55555555, 2'b01, 32'h0, 4'b0000);
        chk("mem_10_err", mem_word(32'h10), 32'hDEADBEEF);

        // Backpressure: response held for five cycles.
        i_req_valid  = 1'b1;
        i_req_we     = 1'b0;
        i_req_funct3 = 3'b010;
        i_req_addr   = 32'h10;
        @(posedge i_clk);
        @(negedge i_clk);
        i_req_valid = 1'b0;
        @(posedge i_clk);
        @(negedge i_clk);
        for (int c = 0; c < 5; c++) begin
            chk("bp.valid", 32'(o_rsp_valid), 32'd1);
            chk("bp.rdata", o_rsp_rdata,      32'hDEADBEEF);
            chk("bp.err",   32'(o_rsp_err),   32'd0);
            chk("bp.ready", 32'(o_req_ready), 32'd0);
            chk("bp.wren",  32'(o_mem_wren),  32'd0);
            chk("bp.bmask", 32'(o_mem_bmask), 32'd0);
            @(negedge i_clk);
        end
        i_rsp_ready = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_rsp_ready = 1'b0;
        chk("bp.rel_ready", 32'(o_req_ready), 32'd1);
        chk("bp.rel_valid", 32'(o_rsp_valid), 32'd0);

        // Reset during the ACCESS cycle of a store aborts it.
        txn("sw_30_pre", 1'b1, 3'b010, 32'h30, 32'h000000A5, 2'b00, 32'h0, 4'b1111);
        i_req_valid  = 1'b1;
        i_req_we     = 1'b1;
        i_req_funct3 = 3'b010;
        i_req_addr   = 32'h30;
        i_req_wdata  = 32'h11223344;
        @(posedge i_clk);
        @(negedge i_clk);
        i_req_valid = 1'b0;
        chk("ar.in_access", 32'(o_mem_wren), 32'd1);
        i_reset = 1'b1;
        #1;
        chk("ar.wren",      32'(o_mem_wren),  32'd0);
        chk("ar.bmask",     32'(o_mem_bmask), 32'd0);
        chk("ar.addr",      32'(o_mem_addr),  32'd0);
        chk("ar.wdata",     o_mem_wdata,      32'd0);
        chk("ar.rsp_valid", 32'(o_rsp_valid), 32'd0);
        chk("ar.rsp_rdata", o_rsp_rdata,      32'd0);
        chk("ar.rsp_err",   32'(o_rsp_err),   32'd0);
        @(posedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b0;
        @(negedge i_clk);
        chk("ar.mem_30",    mem_word(32'h30), 32'h000000A5);
        chk("ar.req_ready", 32'(o_req_ready), 32'd1);
        chk("ar.no_rsp",    32'(o_rsp_valid), 32'd0);
        txn("lw_30", 1'b0, 3'b010, 32'h30, 32'h0, 2'b00, 32'h000000A5, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
